// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock parametrised FIFO with programmable thresholds,
//            occupancy count, error pulses and standard/FWFT read modes.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 14,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AFULL     = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] c_AEMPTY    = (ADDR_WIDTH+1)'(AEMPTY_TH);

    if (AFULL_TH < 1 || AFULL_TH > c_DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= c_DEPTH) begin : g_param_check
        $fatal(1, "sync_fifo_param: AFULL_TH must be 1..DEPTH and AEMPTY_TH 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd_en & ~w_empty;
    // A full FIFO can still take a write when the same edge frees a slot.
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - (ADDR_WIDTH+1)'(1);
            end
            r_overflow  <= wr_en & ~w_wr_acc;
            r_underflow <= rd_en & w_empty;
        end
    end

    if (FWFT == 0) begin : g_std_read
        logic [DATA_WIDTH-1:0] r_data_out;
        logic                  r_data_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data_out   <= '0;
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
        end

        assign data_out   = r_data_out;
        assign data_valid = r_data_valid;
    end else begin : g_fwft_read
        // Head of queue is always presented; rd_en acknowledges it.
        assign data_out   = r_mem[r_rd_ptr];
        assign data_valid = ~w_empty;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL);
    assign almost_empty = (r_count <= c_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Directed self-checking bench for sync_fifo_param, standard and
//            FWFT instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic       f_wr_en;
    logic [7:0] f_data_in;
    logic       f_rd_en;
    logic [7:0] f_data_out;
    logic       f_data_valid;
    logic       f_full;
    logic       f_empty;
    logic       f_almost_full;
    logic       f_almost_empty;
    logic [4:0] f_count;
    logic       f_overflow;
    logic       f_underflow;

    int total = 0;
    int bad   = 0;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .data_valid(f_data_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int         w;
        int         r;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            tick();
            chk("fill_count", count, 32'(i + 1));
            chk("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end
        data_in = 8'hEE;
        tick();
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        wr_en = 1'b0;
        tick();
        chk("ovf_clear", overflow, 0);
        chk("ovf_hold_count", count, 16);

        // Drain
        for (int k = 0; k < 16; k++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_data", data_out, 32'(k));
            chk("drain_valid", data_valid, 1);
            chk("drain_count", count, 32'(15 - k));
            chk("drain_aempty", almost_empty, (15 - k <= 2) ? 1 : 0);
            chk("drain_empty", empty, (k == 15) ? 1 : 0);
        end
        rd_en = 1'b0;
        tick();
        chk("idle_valid", data_valid, 0);
        chk("idle_hold", data_out, 8'h0F);
        chk("idle_udf", underflow, 0);

        // Underflow
        rd_en = 1'b1;
        tick();
        chk("udf_pulse", underflow, 1);
        chk("udf_valid", data_valid, 0);
        chk("udf_count", count, 0);
        rd_en = 1'b0;
        tick();
        chk("udf_clear", underflow, 0);
        rd_en = 1'b1; wr_en = 1'b1; data_in = 8'hA5;
        tick();
        chk("udfw_pulse", underflow, 1);
        chk("udfw_count", count, 1);
        chk("udfw_valid", data_valid, 0);
        rd_en = 1'b0; wr_en = 1'b0;
        tick();
        chk("udfw_clear", underflow, 0);

        // Full with simultaneous read/write
        for (int i = 0; i < 15; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h10 + i);
            tick();
        end
        chk("full2_count", count, 16);
        chk("full2_full", full, 1);
        rd_en = 1'b1; wr_en = 1'b1; data_in = 8'h77;
        tick();
        chk("rw_full_ovf", overflow, 0);
        chk("rw_full_count", count, 16);
        chk("rw_full_data", data_out, 8'hA5);
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("rw_drain", data_out, (k == 15) ? 32'h77 : 32'(8'h10 + k));
        end
        rd_en = 1'b0;
        tick();
        chk("rw_empty", empty, 1);

        // Reset mid-stream at count 5
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h50 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_rst_count", count, 5);
        #2 rst = 1'b1;
        #1;
        chk("mrst_count", count, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_aempty", almost_empty, 1);
        chk("mrst_full", full, 0);
        chk("mrst_valid", data_valid, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_udf", underflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Wrap-around with scoreboard
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h80 + i);
            q.push_back(data_in);
            tick();
        end
        for (int c = 0; c < 40; c++) begin
            w = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 1));
            if (q.size() == 1 && r == 1 && w == 0) r = 0;
            if (q.size() == 15 && w == 1 && r == 0) w = 0;
            wr_en = (w == 1); rd_en = (r == 1); data_in = 8'($urandom);
            exp_b = '0;
            if (r == 1) exp_b = q.pop_front();
            if (w == 1) q.push_back(data_in);
            tick();
            chk("wrap_count", count, 32'(q.size()));
            chk("wrap_valid", data_valid, 32'(r));
            if (r == 1) chk("wrap_data", data_out, exp_b);
        end
        wr_en = 1'b0;
        for (int c = 0; c < 16 && q.size() > 0; c++) begin
            rd_en = 1'b1;
            exp_b = q.pop_front();
            tick();
            chk("wrap_drain", data_out, exp_b);
        end
        rd_en = 1'b0;
        tick();
        chk("wrap_end_empty", empty, 1);

        // FWFT instance
        chk("fw_empty0", f_empty, 1);
        chk("fw_valid0", f_data_valid, 0);
        f_wr_en = 1'b1; f_data_in = 8'h3C;
        tick();
        f_wr_en = 1'b0;
        chk("fw_show", f_data_out, 8'h3C);
        chk("fw_valid", f_data_valid, 1);
        tick();
        chk("fw_hold", f_data_out, 8'h3C);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fw_pop_empty", f_empty, 1);
        chk("fw_pop_valid", f_data_valid, 0);
        f_wr_en = 1'b1; f_data_in = 8'h11;
        tick();
        f_data_in = 8'h22;
        tick();
        f_wr_en = 1'b0;
        chk("fw_head1", f_data_out, 8'h11);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fw_head2", f_data_out, 8'h22);
        chk("fw_count", f_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
